// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider and the arithmetic benches
// that reuse its state encoding and default operand width.
package div_pkg;

    localparam int DEFAULT_D_IN = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        CALC    = 2'b01,
        DONE    = 2'b10,
        RELEASE = 2'b11
    } div_state_t;

endpackage

// File: rtl/seq_signed_div_if.sv
// Request/result bundle between a divide initiator (master) and the divider (slave).
interface seq_signed_div_if
    import div_pkg::*;
#(
    parameter int D_IN = DEFAULT_D_IN
);

    logic            start;
    logic [D_IN-1:0] div_A;
    logic [D_IN-1:0] div_B;
    logic            done;
    logic [D_IN-1:0] Quotient;
    logic [D_IN-1:0] Remainder;
    logic            div_by_zero;

    modport master (
        output start, div_A, div_B,
        input  done, Quotient, Remainder, div_by_zero
    );

    modport slave (
        input  start, div_A, div_B,
        output done, Quotient, Remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, trial-subtract, emit a quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int D_IN = DEFAULT_D_IN
) (
    input  logic [D_IN-1:0] rem_in,
    input  logic [D_IN-1:0] quo_in,
    input  logic [D_IN-1:0] divisor,
    output logic [D_IN-1:0] rem_out,
    output logic [D_IN-1:0] quo_out
);

    logic [D_IN:0] shifted;
    logic [D_IN:0] trial;

    // The partial remainder stays below the divisor, so the shifted value
    // never needs bit D_IN and a set trial MSB is a genuine borrow.
    always_comb begin
        shifted = {rem_in, quo_in[D_IN-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[D_IN]) begin
            rem_out = shifted[D_IN-1:0];
            quo_out = {quo_in[D_IN-2:0], 1'b0};
        end else begin
            rem_out = trial[D_IN-1:0];
            quo_out = {quo_in[D_IN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_signed_div.sv
// Multi-cycle signed divider: captures operands, runs D_IN restoring steps on
// magnitudes, then applies truncate-toward-zero sign rules to the results.
module seq_signed_div
    import div_pkg::*;
#(
    parameter int D_IN = DEFAULT_D_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_signed_div_if.slave bus
);

    localparam int              CNT_W = $clog2(D_IN + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(D_IN);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic [D_IN-1:0]  a_raw;
    logic             b_neg;
    logic [D_IN-1:0]  b_mag;
    logic [D_IN-1:0]  a_mag_in;
    logic [D_IN-1:0]  b_mag_in;
    logic [D_IN-1:0]  rem_reg;
    logic [D_IN-1:0]  quo_reg;
    logic [D_IN-1:0]  rem_next;
    logic [D_IN-1:0]  quo_next;
    logic             b_zero;
    logic [D_IN-1:0]  q_final;
    logic [D_IN-1:0]  r_final;

    div_step #(.D_IN(D_IN)) u_step (
        .rem_in  (rem_reg),
        .quo_in  (quo_reg),
        .divisor (b_mag),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    // Negating the most negative value wraps to 2^(D_IN-1), which is the exact unsigned magnitude.
    always_comb begin
        a_mag_in = bus.div_A[D_IN-1] ? -bus.div_A : bus.div_A;
        b_mag_in = bus.div_B[D_IN-1] ? -bus.div_B : bus.div_B;
        b_zero   = (b_mag == '0);
        q_final  = (a_raw[D_IN-1] ^ b_neg) ? -quo_reg : quo_reg;
        r_final  = a_raw[D_IN-1] ? -rem_reg : rem_reg;
        if (b_zero) begin
            q_final = '1;
            r_final = a_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)     state_next = CALC;
            CALC:    if (count == LAST) state_next = DONE;
            DONE:                       state_next = RELEASE;
            RELEASE: if (!bus.start)    state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.done = (state == DONE);
    end

    // The extra CALC cycle after the last step is where signed results are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count           <= '0;
            a_raw           <= '0;
            b_neg           <= 1'b0;
            b_mag           <= '0;
            rem_reg         <= '0;
            quo_reg         <= '0;
            bus.Quotient    <= '0;
            bus.Remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_raw   <= bus.div_A;
                        b_neg   <= bus.div_B[D_IN-1];
                        b_mag   <= b_mag_in;
                        quo_reg <= a_mag_in;
                        rem_reg <= '0;
                        count   <= '0;
                    end
                end
                CALC: begin
                    if (count != LAST) begin
                        rem_reg <= rem_next;
                        quo_reg <= quo_next;
                        count   <= count + 1'b1;
                    end else begin
                        bus.Quotient    <= q_final;
                        bus.Remainder   <= r_final;
                        bus.div_by_zero <= b_zero;
                        count           <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_div.sv
// Self-checking bench for seq_signed_div at D_IN=8: directed vectors, protocol
// corner cases and random operands against an integer-arithmetic model.
module tb_seq_signed_div;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs [13];

    seq_signed_div_if #(.D_IN(W)) bus ();

    seq_signed_div #(.D_IN(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Plain signed integer division; the -128/-1 case wraps naturally on truncation to W bits.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = W'(ai / bi);
            r  = W'(ai % bi);
            dz = 1'b0;
        end
    endfunction

    // Entered and left at a falling edge with the divider idle.
    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                                  input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
        int edges;
        bit seen;
        bus.div_A = a;
        bus.div_B = b;
        bus.start = 1'b1;
        @(posedge clk);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 30) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check_output("latency", seen ? edges : 999, 9);
        check_output("quotient", bus.Quotient, eq);
        check_output("remainder", bus.Remainder, er);
        check_output("div_by_zero", bus.div_by_zero, edz);
        repeat (hold) begin
            bus.div_A = W'($urandom);
            bus.div_B = W'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_output("single_pulse", bus.done, 1'b0);
            check_output("quotient_hold", bus.Quotient, eq);
        end
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] ra, rb, rq, rr;
        logic         rdz;
        int           pulses;

        vecs[0]  = '{8'd20,  8'd2,   8'd10,  8'h00, 1'b0};
        vecs[1]  = '{8'd11,  8'hFB,  8'hFE,  8'h01, 1'b0};
        vecs[2]  = '{8'hF9,  8'd2,   8'hFD,  8'hFF, 1'b0};
        vecs[3]  = '{8'd55,  8'hF5,  8'hFB,  8'h00, 1'b0};
        vecs[4]  = '{8'h80,  8'hFF,  8'h80,  8'h00, 1'b0};
        vecs[5]  = '{8'd13,  8'h00,  8'hFF,  8'h0D, 1'b1};
        vecs[6]  = '{8'h80,  8'h01,  8'h80,  8'h00, 1'b0};
        vecs[7]  = '{8'h7F,  8'h80,  8'h00,  8'h7F, 1'b0};
        vecs[8]  = '{8'h80,  8'h80,  8'h01,  8'h00, 1'b0};
        vecs[9]  = '{8'h80,  8'h00,  8'hFF,  8'h80, 1'b1};
        vecs[10] = '{8'h00,  8'd5,   8'h00,  8'h00, 1'b0};
        vecs[11] = '{8'd7,   8'd7,   8'h01,  8'h00, 1'b0};
        vecs[12] = '{8'hFF,  8'd5,   8'h00,  8'hFF, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.div_A = '0;
        bus.div_B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_done", bus.done, 1'b0);
        check_output("reset_quotient", bus.Quotient, '0);
        check_output("reset_remainder", bus.Remainder, '0);
        check_output("reset_div_by_zero", bus.div_by_zero, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, 1, vecs[i].q, vecs[i].r, vecs[i].dz);
        end

        // Start held high well past done, then dropped for one cycle and raised again.
        apply_stimulus(8'd100, 8'd7, 5, 8'd14, 8'd2, 1'b0);
        model(8'h9C, 8'd7, rq, rr, rdz);
        apply_stimulus(8'h9C, 8'd7, 1, rq, rr, rdz);

        // Reset during the fourth CALC cycle aborts the operation.
        bus.div_A = 8'd100;
        bus.div_B = 8'd3;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("abort_done", bus.done, 1'b0);
        check_output("abort_quotient", bus.Quotient, '0);
        check_output("abort_remainder", bus.Remainder, '0);
        check_output("abort_div_by_zero", bus.div_by_zero, 1'b0);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done === 1'b1) pulses++;
        end
        check_output("abort_no_pulse", pulses, 0);
        apply_stimulus(8'd20, 8'd2, 1, 8'd10, 8'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : W'($urandom);
            if ($urandom_range(0, 9) == 0) ra = 8'h80;
            model(ra, rb, rq, rr, rdz);
            apply_stimulus(ra, rb, 1, rq, rr, rdz);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_signed_div.md
SEQ_SIGNED_DIV -- requirements
Module: seq_signed_div

Interface
REQ-001 SHALL have parameter: D_IN, default 8, operand/result width in bits (D_IN >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request; held high by initiator until done observed.
REQ-005 SHALL have port: div_A  input  D_IN  signed two's-complement dividend.
REQ-006 SHALL have port: div_B  input  D_IN  signed two's-complement divisor.
REQ-007 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port: Quotient  output  D_IN  signed quotient.
REQ-009 SHALL have port: Remainder  output  D_IN  signed remainder.
REQ-010 SHALL have port: div_by_zero  output  1  set with done when div_B was 0.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE, RELEASE.
REQ-012 IDLE: on edge with start=1, SHALL capture div_A/div_B, go to CALC; inputs ignored afterwards until next capture.
REQ-013 CALC: SHALL perform one restoring shift/subtract step per cycle on unsigned magnitudes, exactly D_IN steps, then go to DONE.
REQ-014 Latency: done SHALL be high in the cycle following edge D_IN+1 counted from the capture edge (capture edge = edge 0), i.e. D_IN+1 edges after capture; fixed for all operands including divide-by-zero.
REQ-015 DONE: done=1 for exactly one cycle, Quotient/Remainder/div_by_zero valid from that cycle; next state RELEASE.
REQ-016 RELEASE: SHALL stay until start sampled 0, then go to IDLE; start held high across done SHALL NOT start a second operation.
REQ-017 Sign rule: quotient truncates toward zero; quotient negative iff operand signs differ and magnitude nonzero; remainder carries dividend's sign; |Remainder| < |div_B|.
REQ-018 Magnitudes SHALL be formed as D_IN-bit unsigned values so |-2^(D_IN-1)| = 2^(D_IN-1) is exact.
REQ-019 Overflow: -2^(D_IN-1) / -1 SHALL give Quotient = -2^(D_IN-1) (wrap), Remainder = 0, div_by_zero = 0.
REQ-020 div_B = 0: Quotient = all ones, Remainder = div_A, div_by_zero = 1.
REQ-021 Quotient, Remainder, div_by_zero SHALL be registered and hold their values until the DONE cycle of the next operation.
REQ-022 done SHALL be 0 in every state other than DONE.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, done=0, Quotient=0, Remainder=0, div_by_zero=0, step counter=0.
REQ-024 Reset asserted mid-CALC SHALL abort the operation; no done pulse for it; after release a fresh start=1 SHALL begin a new operation normally.

Structure
REQ-025 State encodings (2-bit) and default D_IN SHALL live in shared package/header div_pkg, reused by the multiplier-side benches.
REQ-026 One combinational sub-module div_step (one restoring iteration: shift partial remainder, trial subtract, quotient bit) SHALL be instantiated once; sign handling and FSM stay in seq_signed_div.
REQ-027 Step counter SHALL be $clog2(D_IN+1) bits wide.

Verification (D_IN=8)
REQ-028 div_A=20, div_B=2 -> Quotient=8'd10, Remainder=0, div_by_zero=0, done exactly 9 edges after capture, single pulse.
REQ-029 div_A=11, div_B=8'hFB (-5) -> Quotient=8'hFE (-2), Remainder=8'h01; then div_A=8'hF9 (-7), div_B=2 -> Quotient=8'hFD (-3), Remainder=8'hFF (-1).
REQ-030 div_A=55, div_B=8'hF5 (-11) -> Quotient=8'hFB (-5), Remainder=0; div_A=8'h80, div_B=8'hFF -> Quotient=8'h80, Remainder=0.
REQ-031 div_A=13, div_B=0 -> Quotient=8'hFF, Remainder=8'h0D, div_by_zero=1, same latency as REQ-028.
REQ-032 start held high 5 cycles beyond done -> exactly one done pulse; drop start one cycle then raise -> new operation captured.
REQ-033 rst_n pulsed low during 4th CALC cycle -> all outputs 0 immediately, no done; subsequent 20/2 request -> Quotient=10.
